// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter serialising 16-bit accesses onto an 8-bit memory
//
// Purpose: arbitrates between a fetch port (reads only) and an execute port
// (loads/stores) and performs each 16-bit access as two byte cycles
// (low byte at A, high byte at A+1) on a single-port byte memory.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   halt_program                  blocks new grants; in-flight access completes
//   fetch_req/fetch_addr          fetch request (read word at fetch_addr)
//   fetch_gnt/fetch_done          one-cycle grant / completion pulses
//   fetch_rdata                   last word read for fetch
//   ex_req/ex_we/ex_addr/ex_wdata execute request (load or store)
//   ex_gnt/ex_done                one-cycle grant / completion pulses
//   ex_rdata                      last word loaded for execute
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  byte-memory port (1-cycle read latency)
//   busy                          high whenever a transaction is in flight
module mem_port_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_program,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_done,
  output logic [15:0]       fetch_rdata,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [15:0]       ex_wdata,
  output logic              ex_gnt,
  output logic              ex_done,
  output logic [15:0]       ex_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_FIN} state_t;

  // Owner encoding: 0 = fetch, 1 = execute.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_EX    = 1'b1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [7:0]          lo_byte_q, lo_byte_d;
  logic [15:0]         fetch_rdata_q, fetch_rdata_d;
  logic [15:0]         ex_rdata_q, ex_rdata_d;
  logic                fetch_gnt_q, fetch_gnt_d;
  logic                ex_gnt_q, ex_gnt_d;
  logic                fetch_done_q, fetch_done_d;
  logic                ex_done_q, ex_done_d;

  logic                grant_ok;
  logic                pick_ex;

  assign grant_ok = (state_q == S_IDLE) && !halt_program && (fetch_req || ex_req);
  // Execute wins when alone, or on a tie when fetch owned the previous grant.
  assign pick_ex  = ex_req && (!fetch_req || (last_owner_q == OWN_FETCH));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed IDLE->LO->HI->FIN->IDLE walk, no stalls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_ok) state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      owner_q       <= OWN_FETCH;
      last_owner_q  <= OWN_FETCH;
      lo_byte_q     <= '0;
      fetch_rdata_q <= '0;
      ex_rdata_q    <= '0;
      fetch_gnt_q   <= 1'b0;
      ex_gnt_q      <= 1'b0;
      fetch_done_q  <= 1'b0;
      ex_done_q     <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      lo_byte_q     <= lo_byte_d;
      fetch_rdata_q <= fetch_rdata_d;
      ex_rdata_q    <= ex_rdata_d;
      fetch_gnt_q   <= fetch_gnt_d;
      ex_gnt_q      <= ex_gnt_d;
      fetch_done_q  <= fetch_done_d;
      ex_done_q     <= ex_done_d;
    end
  end

  // Datapath next values
  always_comb begin
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    lo_byte_d     = lo_byte_q;
    fetch_rdata_d = fetch_rdata_q;
    ex_rdata_d    = ex_rdata_q;
    fetch_gnt_d   = 1'b0;
    ex_gnt_d      = 1'b0;
    fetch_done_d  = 1'b0;
    ex_done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_ok) begin
          owner_d      = pick_ex ? OWN_EX : OWN_FETCH;
          last_owner_d = pick_ex ? OWN_EX : OWN_FETCH;
          addr_d       = pick_ex ? ex_addr : fetch_addr;
          // Fetch is always a read regardless of ex_we.
          we_d         = pick_ex && ex_we;
          wdata_d      = pick_ex ? ex_wdata : 16'h0000;
          ex_gnt_d     = pick_ex;
          fetch_gnt_d  = !pick_ex;
        end
      end
      S_HI: begin
        // Byte read in LO arrives during HI.
        if (!we_q) lo_byte_d = mem_rdata;
      end
      S_FIN: begin
        // Byte read in HI arrives during FIN.
        if (!we_q) begin
          if (owner_q == OWN_EX) ex_rdata_d    = {mem_rdata, lo_byte_q};
          else                   fetch_rdata_d = {mem_rdata, lo_byte_q};
        end
        ex_done_d    = (owner_q == OWN_EX);
        fetch_done_d = (owner_q == OWN_FETCH);
      end
      default: ;
    endcase
  end

  // Output logic: decoded from state so reset clears the memory port at once.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_LO: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q[7:0];
      end
      S_HI: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_W'(1);
        mem_wdata = wdata_q[15:8];
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign fetch_gnt   = fetch_gnt_q;
  assign ex_gnt      = ex_gnt_q;
  assign fetch_done  = fetch_done_q;
  assign ex_done     = ex_done_q;
  assign fetch_rdata = fetch_rdata_q;
  assign ex_rdata    = ex_rdata_q;

endmodule
